// File: rtl/norm_scan.sv
// norm_scan: iterative CLZ/CLS normalizer for scalar 64, SIMD32 and SIMD16 lanes.
// Scans one byte per lane per cycle (MSB byte first), then returns the per-lane
// count and the operand left-shifted by that count within each lane.
module norm_scan #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SCAN_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] norm_s1,
  input  logic                  norm_op,
  input  logic                  simd_ena,
  input  logic [1:0]            simd_ctl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] norm_result,
  output logic [31:0]           norm_count
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = 7;   // count 0..64
  localparam int unsigned KW    = 3;   // byte index 0..7

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_NORM, S_DONE} state_t;
  typedef enum logic [1:0] {M_SCALAR = 2'd0, M_S32 = 2'd1, M_S16 = 2'd2} mode_t;

  state_t                      state_q, state_d;
  mode_t                       mode_q, mode_d, in_mode;
  logic                        op_q, op_d;
  logic [DATA_WIDTH-1:0]       opnd_q, opnd_d, scan_q, scan_d;
  logic [KW-1:0]               k_q, k_d, last_k;
  logic [LANES-1:0][CW-1:0]    cnt_q, cnt_d, fin;
  logic [LANES-1:0]            found_q, found_d, lane_used;
  logic [DATA_WIDTH-1:0]       res_q, res_d;
  logic [31:0]                 ncnt_q, ncnt_d;
  logic                        ov_q, ov_d, ir_q, ir_d;
  logic [LANES-1:0][KW-1:0]    bidx;
  logic [LANES-1:0][SCAN_BITS-1:0] scan_byte;
  int unsigned                 lane_bytes;

  // Leading zeros of one byte, 8 when the byte is zero.
  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] n;
    logic       hit;
    n   = 4'd0;
    hit = 1'b0;
    for (int j = 7; j >= 0; j--) begin
      if (!hit) begin
        if (b[j]) hit = 1'b1;
        else      n   = n + 4'd1;
      end
    end
    return n;
  endfunction

  // XOR every lane with its own sign so CLS reduces to CLZ.
  function automatic logic [63:0] sign_strip(input logic [63:0] v, input mode_t m);
    logic [63:0] r;
    case (m)
      M_S32:   r = {v[63:32] ^ {32{v[63]}}, v[31:0] ^ {32{v[31]}}};
      M_S16:   r = {v[63:48] ^ {16{v[63]}}, v[47:32] ^ {16{v[47]}},
                    v[31:16] ^ {16{v[31]}}, v[15:0]  ^ {16{v[15]}}};
      default: r = v ^ {64{v[63]}};
    endcase
    return r;
  endfunction

  assign in_mode = (simd_ena && simd_ctl[0]) ? M_S32 :
                   (simd_ena && simd_ctl[1]) ? M_S16 : M_SCALAR;

  assign in_ready    = ir_q;
  assign out_valid   = ov_q;
  assign norm_result = res_q;
  assign norm_count  = ncnt_q;

  // Lane geometry of the latched mode and the byte each lane examines this cycle.
  always_comb begin
    lane_bytes = 8;
    last_k     = 3'd7;
    lane_used  = 4'b0001;
    case (mode_q)
      M_S32:   begin lane_bytes = 4; last_k = 3'd3; lane_used = 4'b0011; end
      M_S16:   begin lane_bytes = 2; last_k = 3'd1; lane_used = 4'b1111; end
      default: ;
    endcase
    for (int unsigned i = 0; i < LANES; i++) begin
      bidx[i]      = KW'(i * lane_bytes) + (last_k - k_q);
      scan_byte[i] = scan_q[{bidx[i], 3'b000} +: SCAN_BITS];
      if (!lane_used[i])  fin[i] = '0;
      else if (op_q)      fin[i] = cnt_q[i] - CW'(1);
      else                fin[i] = cnt_q[i];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_SCALAR;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      scan_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      found_q <= '0;
      res_q   <= '0;
      ncnt_q  <= '0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      scan_q  <= scan_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      res_q   <= res_d;
      ncnt_q  <= ncnt_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state: fixed-length scan, one normalize cycle, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_SCAN;
      S_SCAN: if (k_q == last_k) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (ov_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch at accept, accumulate per byte, shift at normalize.
  always_comb begin
    mode_d  = mode_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    scan_d  = scan_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    res_d   = res_q;
    ncnt_d  = ncnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mode_d  = in_mode;
          op_d    = norm_op;
          opnd_d  = norm_s1;
          scan_d  = norm_op ? sign_strip(norm_s1, in_mode) : norm_s1;
          k_d     = '0;
          cnt_d   = '0;
          found_d = '0;
        end
      end
      S_SCAN: begin
        k_d = k_q + 3'd1;
        for (int unsigned i = 0; i < LANES; i++) begin
          if (lane_used[i] && !found_q[i]) begin
            cnt_d[i]   = cnt_q[i] + CW'(lzc8(scan_byte[i]));
            found_d[i] = |scan_byte[i];
          end
        end
      end
      S_NORM: begin
        case (mode_q)
          M_S32: for (int unsigned i = 0; i < 2; i++)
                   res_d[32*i +: 32] = opnd_q[32*i +: 32] << fin[i];
          M_S16: for (int unsigned i = 0; i < 4; i++)
                   res_d[16*i +: 16] = opnd_q[16*i +: 16] << fin[i];
          default: res_d = opnd_q << fin[0];
        endcase
        for (int unsigned i = 0; i < LANES; i++)
          ncnt_d[8*i +: 8] = {1'b0, fin[i]};
      end
      default: ;
    endcase
  end

  // Registered handshake outputs.
  always_comb begin
    ov_d = 1'b0;
    ir_d = 1'b0;
    if (state_q == S_DONE && !(ov_q && out_ready)) ov_d = 1'b1;
    if (state_d == S_IDLE) ir_d = 1'b1;
  end

endmodule

// File: tb/tb_norm_scan.sv
// Testbench for norm_scan: directed cases plus random operands against a bit-level model.
module tb_norm_scan;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] norm_s1;
  logic        norm_op;
  logic        simd_ena;
  logic [1:0]  simd_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] norm_result;
  logic [31:0] norm_count;

  int n_checks;
  int n_fail;

  norm_scan dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .norm_s1    (norm_s1),
    .norm_op    (norm_op),
    .simd_ena   (simd_ena),
    .simd_ctl   (simd_ctl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .norm_result(norm_result),
    .norm_count (norm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane width from the enable/control encoding.
  function automatic int lane_w(input logic ena, input logic [1:0] ctl);
    if (ena && ctl[0]) return 32;
    if (ena && ctl[1]) return 16;
    return 64;
  endfunction

  // Reference: walk each lane's bits from the top counting leading zeros / sign copies.
  function automatic void model(input logic [63:0] v, input logic cls, input int w,
                                output logic [63:0] r, output logic [31:0] c);
    logic [63:0] msk, lane, sh;
    logic        sgn;
    int          n;
    msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    r = '0;
    c = '0;
    for (int l = 0; l < 64 / w; l++) begin
      lane = (v >> (l * w)) & msk;
      n = 0;
      if (cls) begin
        sgn = lane[w-1];
        for (int b = w - 2; b >= 0; b--) begin
          if (lane[b] == sgn) n++;
          else break;
        end
      end else begin
        for (int b = w - 1; b >= 0; b--) begin
          if (!lane[b]) n++;
          else break;
        end
      end
      sh = (n >= 64) ? 64'd0 : ((lane << n) & msk);
      r = r | (sh << (l * w));
      c = c | (32'(n) << (8 * l));
    end
  endfunction

  // One full operation: accept, latency, result, optional backpressure, release.
  task automatic do_op(input logic [63:0] v, input logic cls, input logic ena,
                       input logic [1:0] ctl, input int stall);
    logic [63:0] er;
    logic [31:0] ec;
    int          w;
    int          lat;
    bit          seen;
    bit          busy_rdy;
    w = lane_w(ena, ctl);
    model(v, cls, w, er, ec);
    @(negedge clk);
    norm_s1 = v; norm_op = cls; simd_ena = ena; simd_ctl = ctl; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs while busy; only the latched operand may matter.
    in_valid = 1'($urandom);
    norm_s1  = {$urandom, $urandom};
    norm_op  = ~cls;
    simd_ena = 1'($urandom);
    simd_ctl = 2'($urandom);
    lat = 0; seen = 0; busy_rdy = 0;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) seen = 1;
      if (in_ready) busy_rdy = 1;
    end
    chk("out_valid_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(w / 8 + 2));
    chk("busy_in_ready", 64'(busy_rdy), 64'd0);
    chk("result", norm_result, er);
    chk("count", 64'(norm_count), 64'(ec));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_result", norm_result, er);
      chk("hold_count", 64'(norm_count), 64'(ec));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v;
    int          sh;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    norm_s1 = '0; norm_op = 1'b0; simd_ena = 1'b0; simd_ctl = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", norm_result, 64'd0);
    chk("rst_count", 64'(norm_count), 64'd0);
    rst_n = 1'b1;

    // Directed cases.
    do_op(64'h0000_0000_0001_0000, 1'b0, 1'b0, 2'b00, 0);
    chk("dir_scalar_cnt", 64'(norm_count), 64'h2F);
    chk("dir_scalar_res", norm_result, 64'h8000_0000_0000_0000);
    do_op(64'h0, 1'b0, 1'b0, 2'b00, 0);
    chk("dir_zero_cnt", 64'(norm_count), 64'd64);
    do_op(64'h8000_0000_0000_0000, 1'b0, 1'b0, 2'b00, 0);
    do_op(64'hFFFF_F000_0000_00FF, 1'b1, 1'b1, 2'b01, 0);
    chk("dir_s32_res", norm_result, 64'h8000_0000_7F80_0000);
    do_op(64'h0001_8000_0000_00F0, 1'b0, 1'b1, 2'b10, 0);
    chk("dir_s16_cnt", 64'(norm_count), 64'h0F00_1008);
    chk("dir_s16_res", norm_result, 64'h8000_8000_0000_F000);
    do_op(64'h0001_8000_0000_00F0, 1'b0, 1'b1, 2'b11, 0);
    do_op(64'h0000_0F00_FFFF_0000, 1'b0, 1'b1, 2'b00, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2'b00, 0);
    chk("dir_cls_ones_res", norm_result, 64'h8000_0000_0000_0000);
    do_op(64'h0000_FFFF_0000_FFFF, 1'b1, 1'b1, 2'b10, 0);
    do_op(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 2'b00, 5);
    do_op(64'h00C0_FFEE_0000_0001, 1'b1, 1'b1, 2'b01, 1);

    // Reset while scanning: nothing from the aborted operation may surface.
    @(negedge clk);
    norm_s1 = 64'h0000_0000_0000_0001; norm_op = 1'b0; simd_ena = 1'b0; simd_ctl = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", norm_result, 64'd0);
    chk("midrst_count", 64'(norm_count), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    // Random operands and modes.
    for (int t = 0; t < 60; t++) begin
      v  = {$urandom, $urandom};
      sh = int'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0: v = 64'h0;
        1: v = 64'hFFFF_FFFF_FFFF_FFFF;
        2: v = v >> sh;
        3: v = ~(v >> sh);
        default: ;
      endcase
      do_op(v, 1'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
